seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle successor to the team's 4-bit combinational ripple adder (A, B, Ci -> Sum, Co).
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register.
- Uses a start/busy/done handshake and reports signed overflow.
- Intended for datapaths where a full-width carry chain misses timing or area budget.

Parameters:
- WIDTH, 16: operand and result width. Must be >= 1.
- CHUNK, 4: bits added per cycle. Must divide WIDTH; elaboration error otherwise.
- NCHUNK, derived: WIDTH/CHUNK, the number of add cycles. Not user-overridable.

Ports:
- Clk  in  1  sole clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  operand A, captured on the accepted Start edge.
- B  in  WIDTH  operand B, captured on the accepted Start edge.
- Ci  in  1  carry-in, captured with operands; ignored when Sub=1.
- Sub  in  1  mode select, captured with operands: 0 = A+B+Ci, 1 = A-B (A + ~B + 1).
- Sum  out  WIDTH  registered result; holds the last result until the next completion.
- Co  out  1  carry out of the MSB. When Sub=1, Co=1 means no borrow.
- Ovf  out  1  two's-complement overflow of the completed operation.
- Busy  out  1  high while in ADD.
- Done  out  1  one-cycle pulse; Sum/Co/Ovf are valid from this cycle onward.

Behaviour:
- Reset: Rst high clears immediately, independent of Clk, including mid-operation.
  - Cleared: state=IDLE, chunk index=0, operand/partial-sum/carry registers=0, Sum=0, Co=0, Ovf=0, Busy=0, Done=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE: Start=1 at an edge -> capture A, B, Sub.
  - Beff = Sub ? ~B : B; carry register = Sub ? 1 : Ci; index=0; go to ADD.
- ADD: each edge adds chunk[index] of A and Beff with the carry register.
  - Writes CHUNK sum bits into the partial-sum register and updates the carry register.
  - index increments after each chunk.
  - The edge processing index=NCHUNK-1 loads Sum, Co and Ovf and goes to DONE.
- DONE: lasts exactly one cycle with Done=1. Next edge: Start=1 accepts a new operation exactly as in IDLE (back-to-back), otherwise go to IDLE.
- Latency: Start accepted at edge t0; Busy=1 after t0 through edge t(NCHUNK); Done=1 for the single cycle after t(NCHUNK). Throughput is one result per NCHUNK+1 cycles.
- Start, A, B, Ci and Sub are ignored while in ADD; operands are never re-sampled mid-operation.
- Sum/Co/Ovf change only on the completing edge (or reset). Partial results are never visible.
- Ovf = (A[MSB] == Beff[MSB]) && (Sum[MSB] != A[MSB]), evaluated on the full-width result.
- All arithmetic is modulo 2^WIDTH. Co is the single carry out of bit WIDTH-1.
- CHUNK == WIDTH (NCHUNK=1): one ADD cycle, then DONE. The index register is kept at a minimum width of 1 bit.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Shared package seq_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
  - a clog2-style function for the index width.
- One combinational sub-module, chunk_adder (CHUNK-bit A, B, Ci -> Sum, Co), is instantiated once and indexed by the chunk counter.
- The FSM, counter and registers stay in the top level.

Test Plan:
- WIDTH=16, CHUNK=4: A=3, B=6, Ci=0, Sub=0, Start pulse -> Done exactly 4 edges after the Start edge; Sum=0x0009, Co=0, Ovf=0; Busy high for 4 cycles.
- A=0xFFFF, B=0x0001, Ci=0 -> Sum=0x0000, Co=1, Ovf=0. A=0x7FFF, B=0x0001 -> Sum=0x8000, Co=0, Ovf=1.
- Sub=1, A=0x0005, B=0x0007, Ci=1 (ignored) -> Sum=0xFFFE, Co=0, Ovf=0. Sub=1, A=0x8000, B=0x0001 -> Sum=0x7FFF, Co=1, Ovf=1.
- Start held high with A/B changing every cycle during ADD -> result reflects only the operands captured at acceptance. Start=1 in the DONE cycle -> second operation starts with no IDLE gap; second Done follows 5 cycles after the first.
- Rst pulsed asynchronously between edges mid-ADD -> Sum/Co/Ovf/Busy/Done go to 0 before the next edge. A subsequent A=13, B=14, Ci=1 -> Sum=0x001C.
- WIDTH=4, CHUNK=1: A=11, B=7, Ci=0 -> Sum=2, Co=1, Done after 4 edges. WIDTH=4, CHUNK=4: A=8, B=8, Ci=1 -> Sum=1, Co=1, Done after 1 edge.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared state encoding and index-width helper for the chunked sequential adder.
// Pure declarations: no latency, no flow control.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational adder slice with carry in/out.
// Zero latency; no flow control.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign sum   = total[CHUNK-1:0];
  assign co    = total[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one shared slice.
// Latency NCHUNK edges after the Start edge, then a one-cycle Done; Start is ignored while Busy.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Co,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  state_t           state;
  state_t           next_state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] beff_q;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic             accept;
  logic             last_chunk;

  logic [CHUNK-1:0] c_sum;
  logic             c_co;
  logic [WIDTH-1:0] full_sum;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_q[idx*CHUNK +: CHUNK]),
    .b   (beff_q[idx*CHUNK +: CHUNK]),
    .ci  (carry),
    .sum (c_sum),
    .co  (c_co)
  );

  // Partial sum with the current chunk merged in; on the last chunk this is the full result.
  always_comb begin
    full_sum = psum;
    full_sum[idx*CHUNK +: CHUNK] = c_sum;
  end

  assign accept     = Start && (state == ST_IDLE || state == ST_DONE);
  assign last_chunk = (idx == LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) next_state = ST_ADD;
      end
      ST_ADD: begin
        Busy = 1'b1;
        if (last_chunk) next_state = ST_DONE;
      end
      ST_DONE: begin
        Done       = 1'b1;
        next_state = Start ? ST_ADD : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      idx    <= '0;
      a_q    <= '0;
      beff_q <= '0;
      psum   <= '0;
      carry  <= 1'b0;
      Sum    <= '0;
      Co     <= 1'b0;
      Ovf    <= 1'b0;
    end else if (accept) begin
      idx    <= '0;
      a_q    <= A;
      beff_q <= Sub ? ~B : B;
      psum   <= '0;
      carry  <= Sub | Ci;
    end else if (state == ST_ADD) begin
      psum  <= full_sum;
      carry <= c_co;
      idx   <= idx + 1'b1;
      if (last_chunk) begin
        idx <= '0;
        Sum <= full_sum;
        Co  <= c_co;
        Ovf <= (a_q[WIDTH-1] == beff_q[WIDTH-1]) && (full_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: reference model plus directed vectors on 16/4, 4/1 and 4/4 builds.
// Outputs sampled on the falling edge or 1 time unit after the rising edge.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        ci = 1'b0, sub = 1'b0;
  logic [15:0] sum;
  logic        co, ovf, busy, done;

  logic        start1 = 1'b0, start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ci4 = 1'b0, sub4 = 1'b0;
  logic [3:0]  sum1, sum4;
  logic        co1, ovf1, busy1, done1;
  logic        co4, ovf4, busy4, done4;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .Clk(clk), .Rst(rst), .Start(start), .A(a), .B(b), .Ci(ci), .Sub(sub),
    .Sum(sum), .Co(co), .Ovf(ovf), .Busy(busy), .Done(done)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) u_dut_w4c1 (
    .Clk(clk), .Rst(rst), .Start(start1), .A(a4), .B(b4), .Ci(ci4), .Sub(sub4),
    .Sum(sum1), .Co(co1), .Ovf(ovf1), .Busy(busy1), .Done(done1)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u_dut_w4c4 (
    .Clk(clk), .Rst(rst), .Start(start4), .A(a4), .B(b4), .Ci(ci4), .Sub(sub4),
    .Sum(sum4), .Co(co4), .Ovf(ovf4), .Busy(busy4), .Done(done4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {ovf, co, sum} from plain 17-bit arithmetic.
  function automatic logic [17:0] model_result(input logic [15:0] x, input logic [15:0] y,
                                               input logic c, input logic s);
    logic [15:0] ye;
    logic [16:0] t;
    logic        v;
    ye = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + 17'(s ? 1'b1 : c);
    v  = (x[15] == ye[15]) && (t[15] != x[15]);
    return {v, t[16], t[15:0]};
  endfunction

  // Model: an accepted request yields its result 4 edges later, with Done for one cycle.
  int          m_left;
  logic [17:0] m_pend;
  logic [15:0] m_sum;
  logic        m_co, m_ovf, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_pend <= '0;
      m_sum  <= '0;
      m_co   <= 1'b0;
      m_ovf  <= 1'b0;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_sum  <= m_pend[15:0];
        m_co   <= m_pend[16];
        m_ovf  <= m_pend[17];
        m_done <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= model_result(a, b, ci, sub);
        m_left <= 4;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !rst) begin
      check("cmp_sum",  sum,  m_sum);
      check("cmp_co",   co,   m_co);
      check("cmp_ovf",  ovf,  m_ovf);
      check("cmp_busy", busy, m_left > 0);
      check("cmp_done", done, m_done);
    end
  end

  // Issue one request on the 16/4 build; operands are scrambled right after acceptance.
  task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s,
                      output int edges, output int busy_n);
    a = x; b = y; ci = c; sub = s; start = 1'b1;
    edges = 0; busy_n = 0;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    if (busy) busy_n++;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_n++;
    end
  endtask

  task automatic check_res(input string name, input int edges, input logic [15:0] es,
                           input logic ec, input logic eo);
    check({name, "_lat"}, edges, 4);
    check({name, "_sum"}, sum, es);
    check({name, "_co"},  co,  ec);
    check({name, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int e, bn;
    #2;
    check("rst_sum",  sum,  16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_co_ovf", {co, ovf}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmp = 1'b1;
    @(posedge clk); #1;

    op16(16'd3, 16'd6, 1'b0, 1'b0, e, bn);
    check_res("add_3_6", e, 16'h0009, 1'b0, 1'b0);
    check("add_3_6_busy_cycles", bn, 4);
    check("add_3_6_done", done, 1'b1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);

    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, e, bn);
    check_res("add_wrap", e, 16'h0000, 1'b1, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, e, bn);
    check_res("add_ovf", e, 16'h8000, 1'b0, 1'b1);
    op16(16'h0005, 16'h0007, 1'b1, 1'b1, e, bn);
    check_res("sub_borrow", e, 16'hFFFE, 1'b0, 1'b0);
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, e, bn);
    check_res("sub_ovf", e, 16'h7FFF, 1'b1, 1'b1);

    // Start held high while operands churn during ADD, then back-to-back from DONE.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    e = 0;
    while (!done && e < 20) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      e++;
    end
    check_res("hold", e, 16'h2345, 1'b0, 1'b0);
    a = 16'h0100; b = 16'h0020; ci = 1'b0; sub = 1'b0;
    e = 0;
    do begin
      @(posedge clk); #1;
      e++;
      if (e == 1) start = 1'b0;
    end while (!done && e < 20);
    check("b2b_gap", e, 5);
    check("b2b_sum", sum, 16'h0120);

    // Asynchronous reset between edges while an operation is in flight.
    a = 16'hAAAA; b = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_sum",  sum,  16'h0000);
    check("arst_flags", {co, ovf, busy, done}, 4'b0000);
    rst = 1'b0;
    @(posedge clk); #1;
    op16(16'd13, 16'd14, 1'b1, 1'b0, e, bn);
    check_res("post_rst", e, 16'h001C, 1'b0, 1'b0);

    // WIDTH=4, CHUNK=1
    @(posedge clk); #1;
    a4 = 4'd11; b4 = 4'd7; ci4 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("w4c1_busy", busy1, 1'b1);
    e = 0;
    while (!done1 && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    check("w4c1_lat", e, 4);
    check("w4c1_sum", sum1, 4'd2);
    check("w4c1_co",  co1,  1'b1);
    check("w4c1_ovf", ovf1, 1'b0);

    // WIDTH=4, CHUNK=4
    @(posedge clk); #1;
    a4 = 4'd8; b4 = 4'd8; ci4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("w4c4_busy", busy4, 1'b1);
    e = 0;
    while (!done4 && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    check("w4c4_lat", e, 1);
    check("w4c4_sum", sum4, 4'd1);
    check("w4c4_co",  co4,  1'b1);
    check("w4c4_ovf", ovf4, 1'b1);

    @(posedge clk); #1;
    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

endmodule
